// File: rtl/lsu_pkg.sv
// lsu_pkg: opcode constants, FSM state and access-size enums shared by the load/store unit
package lsu_pkg;

    localparam logic [5:0] OP_LWZ = 6'd32;
    localparam logic [5:0] OP_LBZ = 6'd34;
    localparam logic [5:0] OP_STW = 6'd36;
    localparam logic [5:0] OP_STB = 6'd38;
    localparam logic [5:0] OP_LHZ = 6'd40;
    localparam logic [5:0] OP_LHA = 6'd42;
    localparam logic [5:0] OP_STH = 6'd44;
    localparam logic [5:0] OP_LD  = 6'd58;
    localparam logic [5:0] OP_STD = 6'd62;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} acc_size_e;

    typedef struct packed {
        logic      legal;
        logic      load;
        acc_size_e size;
        logic      sext;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t i;
        i = '{legal: 1'b1, load: 1'b1, size: SZ_B, sext: 1'b0};
        case (op)
            OP_LBZ: ;
            OP_LHZ: i.size = SZ_H;
            OP_LHA: begin i.size = SZ_H; i.sext = 1'b1; end
            OP_LWZ: i.size = SZ_W;
            OP_LD:  i.size = SZ_D;
            OP_STB: i.load = 1'b0;
            OP_STH: begin i.load = 1'b0; i.size = SZ_H; end
            OP_STW: begin i.load = 1'b0; i.size = SZ_W; end
            OP_STD: begin i.load = 1'b0; i.size = SZ_D; end
            default: i.legal = 1'b0;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: memory-side bus of the load/store unit (master = unit, slave = memory)
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [5:0]        mem_opcode;
    logic              mem_read;
    logic              mem_write;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_opcode, mem_read, mem_write,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_opcode, mem_read, mem_write,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the accessed low bytes of read data and zero/sign-extends them
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  acc_size_e         size,
    input  logic              sext,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);

    // pick the access width and fill the upper bits with zero or the sign bit
    always_comb begin
        data = size == SZ_B ? {{(DATA_W-8){sext & rdata[7]}}, rdata[7:0]} :
               size == SZ_H ? {{(DATA_W-16){sext & rdata[15]}}, rdata[15:0]} :
               size == SZ_W ? {{(DATA_W-32){sext & rdata[31]}}, rdata[31:0]} :
               rdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: D/DS-form load/store sequencer (IDLE->ACCESS->DONE) with ack timeout; LSU_MISALIGN_TRAP_EN traps misaligned EAs
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rt,
    input  logic [4:0]        ra,
    input  logic [15:0]       d,
    input  logic [DATA_W-1:0] ra_val,
    input  logic [DATA_W-1:0] rs_val,
    load_store_unit_if.master mem,
    output logic              wb_valid,
    output logic [4:0]        wb_rt,
    output logic [DATA_W-1:0] wb_data,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e        state;
    logic [CW-1:0]     cnt;
    logic [4:0]        rt_q;
    acc_size_e         size_q;
    logic              sext_q;
    logic              load_q;
    op_info_t          info;
    logic [15:0]       disp16;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] ld_data;
    logic              misal;

    assign info      = decode_op(opcode);
    assign req_ready = state == ST_IDLE;
    assign disp16    = (opcode == OP_LD || opcode == OP_STD) ? {d[15:2], 2'b00} : d;
    assign ea        = (ra == 5'd0 ? '0 : ADDR_W'(ra_val)) + {{(ADDR_W-16){disp16[15]}}, disp16};
    assign st_data   = info.size == SZ_B ? DATA_W'(rs_val[7:0]) :
                       info.size == SZ_H ? DATA_W'(rs_val[15:0]) :
                       info.size == SZ_W ? DATA_W'(rs_val[31:0]) :
                       rs_val;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal = |(ea[2:0] & 3'((4'd1 << info.size) - 4'd1));
`else
    assign misal = 1'b0;
`endif

    lsu_load_align #(.DATA_W(DATA_W)) u_align (
        .size  (size_q),
        .sext  (sext_q),
        .rdata (mem.mem_rdata),
        .data  (ld_data)
    );

    // sequencer: latch request, hold the strobe until ack or timeout, then pulse done for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            rt_q           <= '0;
            size_q         <= SZ_B;
            sext_q         <= 1'b0;
            load_q         <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_wdata  <= '0;
            mem.mem_opcode <= '0;
            mem.mem_read   <= 1'b0;
            mem.mem_write  <= 1'b0;
            wb_valid       <= 1'b0;
            wb_rt          <= '0;
            wb_data        <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            wb_valid <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    cnt            <= '0;
                    rt_q           <= rt;
                    size_q         <= info.size;
                    sext_q         <= info.sext;
                    load_q         <= info.load;
                    mem.mem_addr   <= ea;
                    mem.mem_wdata  <= st_data;
                    mem.mem_opcode <= opcode;
                    if (!info.legal || misal) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state         <= ST_ACCESS;
                        mem.mem_read  <= info.load;
                        mem.mem_write <= !info.load;
                    end
                end
                ST_ACCESS: if (mem.mem_ack) begin
                    state         <= ST_DONE;
                    done          <= 1'b1;
                    mem.mem_read  <= 1'b0;
                    mem.mem_write <= 1'b0;
                    if (load_q) begin
                        wb_valid <= 1'b1;
                        wb_rt    <= rt_q;
                        wb_data  <= ld_data;
                    end
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state         <= ST_DONE;
                    done          <= 1'b1;
                    err           <= 1'b1;
                    mem.mem_read  <= 1'b0;
                    mem.mem_write <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
